// File: rtl/seg_pkg.sv
// Shared constants and character codes for the seven-segment display path.
// The character-to-cathode decoder downstream of the scanner uses the same codes.
package seg_pkg;

  localparam int CHAR_W              = 4;
  localparam int DEFAULT_REFRESH_DIV = 100000;
  localparam int NUM_CHARS           = 12;

  typedef enum logic [CHAR_W-1:0] {
    CH_G = 4'd0,
    CH_L = 4'd1,
    CH_I = 4'd2,
    CH_D = 4'd3,
    CH_E = 4'd4,
    CH_R = 4'd5,
    CH_B = 4'd6,
    CH_A = 4'd7,
    CH_N = 4'd8,
    CH_K = 4'd9,
    CH_O = 4'd10,
    CH_C = 4'd11
  } char_code_e;

endpackage

// File: rtl/seg_digit_scanner_if.sv
// Upstream text-load port plus the display-side outputs of the digit scanner.
interface seg_digit_scanner_if #(
  parameter int NUM_DIGITS = 8,
  parameter int CHAR_W     = seg_pkg::CHAR_W
);

  logic                         load;
  logic [NUM_DIGITS*CHAR_W-1:0] load_chars;
  logic [NUM_DIGITS-1:0]        load_blank;
  logic [CHAR_W-1:0]            char;
  logic [NUM_DIGITS-1:0]        anode;
  logic                         frame_done;
  logic                         pending;

  modport master (
    output load, load_chars, load_blank,
    input  char, anode, frame_done, pending
  );

  modport slave (
    input  load, load_chars, load_blank,
    output char, anode, frame_done, pending
  );

endinterface

// File: rtl/seg_digit_scanner_prescaler.sv
// Digit-slot prescaler: wraps every DIV cycles, flags the last cycle of a slot
// and whether the upcoming count falls inside the anti-ghosting guard window.
module refresh_prescaler #(
  parameter int DIV   = seg_pkg::DEFAULT_REFRESH_DIV,
  parameter int GUARD = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic guard_d
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // guard_d looks at the next count so registered outputs line up with it
  always_comb begin
    tick    = (cnt_q == CNT_W'(DIV - 1));
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    guard_d = (cnt_d < CNT_W'(GUARD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_digit_scanner.sv
// Eight-digit seven-segment multiplexer with a double-buffered text line that
// is committed only at frame boundaries so the display never tears.
module seg_digit_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int CHAR_W       = seg_pkg::CHAR_W,
  parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
  parameter int BLANK_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  seg_digit_scanner_if.slave bus
);

  localparam int DIG_W  = $clog2(NUM_DIGITS);
  localparam int LINE_W = NUM_DIGITS * CHAR_W;
  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);

  logic tick;
  logic guard_d;

  refresh_prescaler #(
    .DIV   (REFRESH_DIV),
    .GUARD (BLANK_CYCLES)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .guard_d (guard_d)
  );

  logic                  boundary;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [LINE_W-1:0]     active_chars_q, active_chars_d;
  logic [NUM_DIGITS-1:0] active_blank_q, active_blank_d;
  logic [LINE_W-1:0]     shadow_chars_q, shadow_chars_d;
  logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [CHAR_W-1:0]     char_q, char_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [NUM_DIGITS-1:0] digit_onehot;

  always_comb begin
    boundary = tick && (digit_q == LAST_DIGIT);
    digit_d  = digit_q;
    if (tick) begin
      digit_d = boundary ? '0 : digit_q + 1'b1;
    end
  end

  // A load landing on the boundary cycle skips the shadow and goes live directly
  always_comb begin
    active_chars_d = active_chars_q;
    active_blank_d = active_blank_q;
    shadow_chars_d = shadow_chars_q;
    shadow_blank_d = shadow_blank_q;
    pending_d      = pending_q;
    if (boundary) begin
      pending_d = 1'b0;
      if (bus.load) begin
        active_chars_d = bus.load_chars;
        active_blank_d = bus.load_blank;
      end else if (pending_q) begin
        active_chars_d = shadow_chars_q;
        active_blank_d = shadow_blank_q;
      end
    end else if (bus.load) begin
      shadow_chars_d = bus.load_chars;
      shadow_blank_d = bus.load_blank;
      pending_d      = 1'b1;
    end
  end

  // Outputs are decoded from next state so they change together with the digit
  always_comb begin
    digit_onehot          = '0;
    digit_onehot[digit_d] = 1'b1;
    char_d                = active_chars_d[int'(digit_d)*CHAR_W +: CHAR_W];
    anode_d               = (guard_d || active_blank_d[digit_d]) ? '1 : ~digit_onehot;
    frame_done_d          = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q        <= '0;
      active_chars_q <= '0;
      active_blank_q <= '1;
      shadow_chars_q <= '0;
      shadow_blank_q <= '0;
      pending_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      char_q         <= '0;
      anode_q        <= '1;
    end else begin
      digit_q        <= digit_d;
      active_chars_q <= active_chars_d;
      active_blank_q <= active_blank_d;
      shadow_chars_q <= shadow_chars_d;
      shadow_blank_q <= shadow_blank_d;
      pending_q      <= pending_d;
      frame_done_q   <= frame_done_d;
      char_q         <= char_d;
      anode_q        <= anode_d;
    end
  end

  assign bus.char       = char_q;
  assign bus.anode      = anode_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Bench for seg_digit_scanner: small display (4 digits, 8-cycle slots, 2 guard
// cycles) checked against a time-indexed reference model plus constant tables.
module tb_seg_digit_scanner;
  import seg_pkg::*;

  localparam int ND    = 4;
  localparam int CW    = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * DIV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_digit_scanner_if #(.NUM_DIGITS(ND), .CHAR_W(CW)) bus ();

  seg_digit_scanner #(
    .NUM_DIGITS   (ND),
    .CHAR_W       (CW),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset plus the live/shadow text
  int                  t;
  logic [ND*CW-1:0]    m_chars, m_sh_chars;
  logic [ND-1:0]       m_blank, m_sh_blank;
  bit                  m_pending, m_fd;

  typedef struct {
    logic [CW-1:0] ch;
    logic [ND-1:0] an;
  } slot_t;

  slot_t blig_tbl [ND];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, got, exp);
    end
  endtask

  function automatic logic [ND-1:0] exp_anode();
    int d = (t / DIV) % ND;
    int p = t % DIV;
    if (p < BLK || m_blank[d]) return '1;
    return ~(ND'(1) << d);
  endfunction

  function automatic logic [CW-1:0] exp_char();
    int d = (t / DIV) % ND;
    return m_chars[d*CW +: CW];
  endfunction

  task automatic step(input bit r, input bit ld, input logic [ND*CW-1:0] ch, input logic [ND-1:0] bl);
    bit bnd;
    rst            = r;
    bus.load       = ld;
    bus.load_chars = ch;
    bus.load_blank = bl;
    @(posedge clk);
    if (r) begin
      t         = 0;
      m_chars   = '0;
      m_blank   = '1;
      m_pending = 1'b0;
      m_fd      = 1'b0;
    end else begin
      bnd  = ((t % FRAME) == FRAME - 1);
      m_fd = bnd;
      if (bnd) begin
        if (ld) begin
          m_chars = ch;
          m_blank = bl;
        end else if (m_pending) begin
          m_chars = m_sh_chars;
          m_blank = m_sh_blank;
        end
        m_pending = 1'b0;
      end else if (ld) begin
        m_sh_chars = ch;
        m_sh_blank = bl;
        m_pending  = 1'b1;
      end
      t++;
    end
    #1;
    check("model_anode", bus.anode, exp_anode());
    check("model_char", bus.char, exp_char());
    check("model_frame_done", bus.frame_done, m_fd);
    check("model_pending", bus.pending, m_pending);
    rst      = 1'b0;
    bus.load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0);
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) step(0, 0, '0, '0);
  endtask

  initial begin
    int fd_cnt, bad, strobed, first_fd;
    bit pend_seen;
    int d;

    blig_tbl[0] = '{ch: 4'd0, an: 4'b1110};
    blig_tbl[1] = '{ch: 4'd2, an: 4'b1101};
    blig_tbl[2] = '{ch: 4'd1, an: 4'b1011};
    blig_tbl[3] = '{ch: 4'd6, an: 4'b0111};

    rst = 1'b1; bus.load = 1'b0; bus.load_chars = '0; bus.load_blank = '0;
    t = 0; m_chars = '0; m_blank = '1; m_sh_chars = '0; m_sh_blank = '0;
    m_pending = 0; m_fd = 0;

    // 1: idle after reset, fully blanked, frame pulses every FRAME cycles
    step(1, 0, '0, '0);
    check("reset_anode", bus.anode, 4'hF);
    check("reset_char", bus.char, 4'h0);
    check("reset_frame_done", bus.frame_done, 1'b0);
    check("reset_pending", bus.pending, 1'b0);
    fd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step(0, 0, '0, '0);
      if (bus.frame_done) fd_cnt++;
    end
    check("t1_fd_count", fd_cnt, 2);

    // 2: mid-frame load of BLIG, visible from the next frame via constant table
    idle(5);
    step(0, 1, {CH_B, CH_L, CH_I, CH_G}, 4'b0000);
    check("t2_pending", bus.pending, 1'b1);
    run_to(0);
    check("t2_pending_cleared", bus.pending, 1'b0);
    for (int dd = 0; dd < ND; dd++) begin
      for (int p = 0; p < DIV; p++) begin
        check("t2_tbl_char", bus.char, blig_tbl[dd].ch);
        check("t2_tbl_anode", bus.anode, (p < BLK) ? 4'hF : blig_tbl[dd].an);
        step(0, 0, '0, '0);
      end
    end

    // 3: two loads in one frame, only the last shows
    idle(3);
    step(0, 1, {CH_E, CH_E, CH_E, CH_E}, 4'b0000);
    idle(4);
    step(0, 1, {CH_C, CH_O, CH_D, CH_E}, 4'b0000);
    run_to(0);
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (bus.anode != 4'hF && bus.anode != 4'b1110 && bus.char == CH_E) bad++;
      step(0, 0, '0, '0);
    end
    check("t3_no_eeee", bad, 0);

    // 4: load exactly on the boundary cycle
    run_to(FRAME - 1);
    step(0, 1, {CH_B, CH_A, CH_N, CH_K}, 4'b0000);
    fd_cnt    = bus.frame_done ? 1 : 0;
    pend_seen = bus.pending;
    for (int i = 1; i < FRAME; i++) begin
      step(0, 0, '0, '0);
      if (bus.frame_done) fd_cnt++;
      if (bus.pending) pend_seen = 1'b1;
      if (i == BLK) begin
        check("t4_char_digit0", bus.char, 4'd9);
        check("t4_anode_digit0", bus.anode, 4'b1110);
      end
    end
    check("t4_fd_once", fd_cnt, 1);
    check("t4_pending_never", pend_seen, 1'b0);

    // 5: blank mask 0101
    idle(3);
    step(0, 1, {CH_C, CH_A, CH_K, CH_E}, 4'b0101);
    run_to(0);
    bad = 0; strobed = 0;
    for (int i = 0; i < FRAME; i++) begin
      d = (i / DIV);
      if ((d == 0 || d == 2) && bus.anode != 4'hF) bad++;
      if ((d == 1 || d == 3) && bus.anode == ~(4'b0001 << d)) strobed++;
      step(0, 0, '0, '0);
    end
    check("t5_blanked_dark", bad, 0);
    check("t5_strobed_cycles", strobed, 2 * (DIV - BLK));

    // 6: reset mid-slot on digit 2 with a pending load
    idle(17);
    step(0, 1, {CH_R, CH_E, CH_D, CH_O}, 4'b0000);
    idle(2);
    check("t6_pending_before", bus.pending, 1'b1);
    step(1, 0, '0, '0);
    check("t6_anode", bus.anode, 4'hF);
    check("t6_char", bus.char, 4'h0);
    check("t6_pending", bus.pending, 1'b0);
    check("t6_frame_done", bus.frame_done, 1'b0);
    first_fd = -1;
    for (int i = 1; i <= FRAME + 8 && first_fd < 0; i++) begin
      step(0, 0, '0, '0);
      if (bus.frame_done) first_fd = i;
    end
    check("t6_first_frame_len", first_fd, FRAME);

    // 7: random traffic including boundary loads and occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0),
           16'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_digit_scanner.md
Name: seg_digit_scanner

Overview:
Time-multiplexes an 8-digit seven-segment display. Holds a double-buffered line of 4-bit character codes plus a per-digit blank mask, and walks the digits at a fixed refresh rate. Drives the active-low anode strobe directly, and supplies the current digit's character code to the downstream character-to-cathode decoder. Text updates from upstream message/pattern logic are committed only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (>=2)
CHAR_W, 4, character code width
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); must be > BLANK_CYCLES+1
BLANK_CYCLES, 4, anti-ghosting cycles with all anodes off at the start of each slot

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
load  in  1  single-cycle strobe; captures load_chars/load_blank into the shadow buffer
load_chars  in  NUM_DIGITS*CHAR_W  digit i code at [i*CHAR_W +: CHAR_W]; digit 0 is rightmost
load_blank  in  NUM_DIGITS  1 = digit i dark
char  out  CHAR_W  code of the currently strobed digit, to the cathode decoder
anode  out  NUM_DIGITS  active-low one-hot digit enable
frame_done  out  1  one-cycle pulse when the last digit slot ends
pending  out  1  shadow buffer holds an uncommitted load

Behaviour:
- Reset (rst=1 at an edge): prescaler=0, digit=0, active chars=0, active blank mask=all 1, shadow cleared, pending=0, anode=all 1, char=0, frame_done=0. Reset takes priority over everything, including an in-flight load or mid-frame state.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. The cycle where count==REFRESH_DIV-1 is a tick.
- On a tick, digit advances by 1 and wraps NUM_DIGITS-1 -> 0. The wrap is the frame boundary.
- At the frame boundary, frame_done is 1 for exactly the following cycle. If pending=1 (or load is asserted that cycle), the shadow is copied into the active buffer and pending clears.
- load, not at a boundary: shadow <= inputs, pending <= 1. Multiple loads before a boundary: the last one wins.
- load on the boundary cycle: the load data bypasses the shadow, is committed directly into the active buffer, and pending=0.
- Outputs are registered and reflect the new digit one cycle after the tick.
  - char = active_chars[digit].
  - anode = all 1 while the prescaler is below BLANK_CYCLES, or if blank[digit]=1.
  - Otherwise anode = ~(1<<digit).
- char still tracks digit during guard and blank cycles, because the decoder is purely combinational.
- No combinational path from load to any output.

Decomposition:
- Shared package seg_pkg holds:
  - CHAR_W=4
  - DEFAULT_REFRESH_DIV
  - character code constants: CH_G=0, CH_L=1, CH_I=2, CH_D=3, CH_E=4, CH_R=5, CH_B=6, CH_A=7, CH_N=8, CH_K=9, CH_O=10, CH_C=11
  - NUM_CHARS=12
- One sub-module is natural: refresh_prescaler (counter, tick, and guard flag for count<BLANK_CYCLES), parameterised by DIV and GUARD.
- Digit counter, double buffer and anode decode stay in seg_digit_scanner.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless noted):
1. Release reset, hold load=0 for 64 cycles -> anode stays 4'b1111 (mask all blank), char=0, frame_done pulses every 32 cycles at the boundary.
2. load chars={B,L,I,G}={6,1,2,0}, blank=0 mid-frame -> pending=1 until the next boundary; afterwards, digit 0 shows char=0 with anode=1110 after 2 dark cycles, then digit 1 shows char=2/1101, digit 2 shows 1/1011, digit 3 shows 6/0111; each slot is 8 cycles with the first 2 at anode=1111.
3. Two loads in one frame ({E,E,E,E} then {C,O,D,E}) -> the next frame shows C,O,D,E only; E,E,E,E never appears on char while anode is active.
4. load asserted exactly on the boundary cycle -> the new text is visible in the very next frame, pending never reads 1, frame_done still pulses once.
5. blank=4'b0101 with valid chars -> anode stays 1111 during the digit 0 and digit 2 slots; digits 1 and 3 are strobed normally.
6. Assert rst for 1 cycle mid-slot on digit 2 with pending=1 -> the next cycle shows anode=1111, char=0, pending=0, frame_done=0, and counting restarts at digit 0 with a full slot length.
